// File: rtl/csi_rx_dly_cal.sv
// Per-lane IDELAY tap auto-calibration for CSI-2 D-PHY data lanes: sweeps every
// tap, scores HS sync-byte hits, and loads the centre of the longest passing window.
module csi_rx_dly_cal #(
    parameter int         NUM_LANES   = 2,
    parameter int         TAP_W       = 5,
    parameter logic [7:0] SYNC_BYTE   = 8'hB8,
    parameter int         SETTLE      = 4,
    parameter int         DWELL       = 1024,
    parameter int         MIN_HITS    = 2,
    parameter int         MIN_WINDOW  = 4,
    parameter int         DEFAULT_TAP = 3
) (
    input  logic                             byte_clock,
    input  logic                             reset_n,
    input  logic                             cal_start,
    input  logic [NUM_LANES*8-1:0]           deser_in,
    output logic [NUM_LANES*TAP_W-1:0]       tap_out,
    output logic [NUM_LANES-1:0]             tap_ld,
    output logic                             cal_busy,
    output logic                             cal_done,
    output logic [NUM_LANES-1:0]             cal_fail,
    output logic [NUM_LANES*(TAP_W+1)-1:0]   win_len
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_DWELL  = 3'd3;
    localparam logic [2:0] ST_EVAL   = 3'd4;
    localparam logic [2:0] ST_APPLY  = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;

    localparam int CNT_W = $clog2(SETTLE + DWELL + 1);
    localparam int HIT_W = $clog2(MIN_HITS + 1);
    localparam int LEN_W = TAP_W + 1;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST  = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [TAP_W-1:0] TAP_MAX     = {TAP_W{1'b1}};
    localparam logic [TAP_W-1:0] TAP_ONE     = TAP_W'(1);
    localparam logic [TAP_W-1:0] DEF_TAP     = TAP_W'(DEFAULT_TAP);
    localparam logic [HIT_W-1:0] HITS_SAT    = HIT_W'(MIN_HITS);
    localparam logic [HIT_W-1:0] HIT_ONE     = HIT_W'(1);
    localparam logic [HIT_W-1:0] HIT_ZERO    = HIT_W'(0);
    localparam logic [LEN_W-1:0] LEN_ONE     = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_ZERO    = LEN_W'(0);
    localparam logic [LEN_W-1:0] MIN_WIN     = LEN_W'(MIN_WINDOW);

    logic [2:0]                 state_r, state_s;
    logic [CNT_W-1:0]           cnt_r;
    logic [TAP_W-1:0]           tap_idx_r;

    logic [7:0]                 prev_r     [NUM_LANES];
    logic [15:0]                win_s      [NUM_LANES];
    logic [NUM_LANES-1:0]       hit_s, hit_r;
    logic [2:0]                 off_s      [NUM_LANES];
    logic [2:0]                 off_r      [NUM_LANES];

    logic [HIT_W-1:0]           hits_r     [NUM_LANES];
    logic [2:0]                 ref_off_r  [NUM_LANES];
    logic [NUM_LANES-1:0]       mism_r;
    logic [LEN_W-1:0]           cur_len_r  [NUM_LANES];
    logic [TAP_W-1:0]           cur_start_r[NUM_LANES];
    logic [LEN_W-1:0]           best_len_r [NUM_LANES];
    logic [TAP_W-1:0]           best_start_r[NUM_LANES];

    logic [NUM_LANES-1:0]       pass_s;
    logic [LEN_W-1:0]           nlen_s     [NUM_LANES];
    logic [TAP_W-1:0]           nstart_s   [NUM_LANES];
    logic [LEN_W-1:0]           center_s   [NUM_LANES];

    logic [NUM_LANES*TAP_W-1:0] tap_out_r;
    logic [NUM_LANES-1:0]       tap_ld_r;
    logic                       cal_busy_r;
    logic                       cal_done_r;
    logic [NUM_LANES-1:0]       cal_fail_r;
    logic [NUM_LANES*LEN_W-1:0] win_len_r;

    assign tap_out  = tap_out_r;
    assign tap_ld   = tap_ld_r;
    assign cal_busy = cal_busy_r;
    assign cal_done = cal_done_r;
    assign cal_fail = cal_fail_r;
    assign win_len  = win_len_r;

    // Sync search across the previous+current byte; descending scan lets the lowest offset win.
    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            win_s[l] = {deser_in[l*8 +: 8], prev_r[l]};
            hit_s[l] = 1'b0;
            off_s[l] = 3'd0;
            for (int k = 7; k >= 0; k--) begin
                hit_s[l] = hit_s[l] | (win_s[l][k +: 8] == SYNC_BYTE);
                off_s[l] = (win_s[l][k +: 8] == SYNC_BYTE) ? 3'(k) : off_s[l];
            end
        end
    end

    // Registered sync-detect pipeline per lane.
    always_ff @(posedge byte_clock or negedge reset_n) begin
        if (!reset_n) begin
            hit_r <= '0;
            for (int l = 0; l < NUM_LANES; l++) begin
                prev_r[l] <= 8'h00;
                off_r[l]  <= 3'd0;
            end
        end else begin
            hit_r <= hit_s;
            for (int l = 0; l < NUM_LANES; l++) begin
                prev_r[l] <= deser_in[l*8 +: 8];
                off_r[l]  <= off_s[l];
            end
        end
    end

    // Next-state decode for the sweep sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:   state_s = cal_start ? ST_LOAD : ST_IDLE;
            ST_LOAD:   state_s = ST_SETTLE;
            ST_SETTLE: state_s = (cnt_r == SETTLE_LAST) ? ST_DWELL : ST_SETTLE;
            ST_DWELL:  state_s = (cnt_r == DWELL_LAST) ? ST_EVAL : ST_DWELL;
            ST_EVAL:   state_s = (tap_idx_r == TAP_MAX) ? ST_APPLY : ST_LOAD;
            ST_APPLY:  state_s = ST_DONE;
            ST_DONE:   state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Per-lane window tracking for the tap under evaluation, and the final centre tap.
    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            pass_s[l]   = (hits_r[l] == HITS_SAT) && !mism_r[l];
            nlen_s[l]   = pass_s[l] ? (cur_len_r[l] + LEN_ONE) : LEN_ZERO;
            nstart_s[l] = (pass_s[l] && (cur_len_r[l] == LEN_ZERO)) ? tap_idx_r : cur_start_r[l];
            center_s[l] = {1'b0, best_start_r[l]} + (best_len_r[l] >> 1);
        end
    end

    // Phase counter for SETTLE and DWELL; restarts on every state change.
    always_ff @(posedge byte_clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= '0;
        end else if (state_s != state_r) begin
            cnt_r <= '0;
        end else if ((state_r == ST_SETTLE) || (state_r == ST_DWELL)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= '0;
        end
    end

    // Sweep sequencer, hit scoring, window trackers and registered outputs.
    always_ff @(posedge byte_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            tap_idx_r  <= '0;
            mism_r     <= '0;
            tap_out_r  <= {NUM_LANES{DEF_TAP}};
            tap_ld_r   <= '0;
            cal_busy_r <= 1'b0;
            cal_done_r <= 1'b0;
            cal_fail_r <= '0;
            win_len_r  <= '0;
            for (int l = 0; l < NUM_LANES; l++) begin
                hits_r[l]       <= HIT_ZERO;
                ref_off_r[l]    <= 3'd0;
                cur_len_r[l]    <= LEN_ZERO;
                cur_start_r[l]  <= '0;
                best_len_r[l]   <= LEN_ZERO;
                best_start_r[l] <= '0;
            end
        end else begin
            state_r  <= state_s;
            tap_ld_r <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (cal_start) begin
                        cal_done_r <= 1'b0;
                        cal_fail_r <= '0;
                        win_len_r  <= '0;
                        cal_busy_r <= 1'b1;
                        tap_idx_r  <= '0;
                        mism_r     <= '0;
                        for (int l = 0; l < NUM_LANES; l++) begin
                            hits_r[l]       <= HIT_ZERO;
                            ref_off_r[l]    <= 3'd0;
                            cur_len_r[l]    <= LEN_ZERO;
                            cur_start_r[l]  <= '0;
                            best_len_r[l]   <= LEN_ZERO;
                            best_start_r[l] <= '0;
                        end
                    end
                end
                ST_LOAD: begin
                    tap_out_r <= {NUM_LANES{tap_idx_r}};
                    tap_ld_r  <= {NUM_LANES{1'b1}};
                end
                ST_DWELL: begin
                    for (int l = 0; l < NUM_LANES; l++) begin
                        if (hit_r[l]) begin
                            if (hits_r[l] == HIT_ZERO) begin
                                ref_off_r[l] <= off_r[l];
                            end else if (off_r[l] != ref_off_r[l]) begin
                                mism_r[l] <= 1'b1;
                            end
                            if (hits_r[l] != HITS_SAT) begin
                                hits_r[l] <= hits_r[l] + HIT_ONE;
                            end
                        end
                    end
                end
                ST_EVAL: begin
                    for (int l = 0; l < NUM_LANES; l++) begin
                        cur_len_r[l]   <= nlen_s[l];
                        cur_start_r[l] <= nstart_s[l];
                        // Strict compare keeps the lowest window on a tie.
                        if (nlen_s[l] > best_len_r[l]) begin
                            best_len_r[l]   <= nlen_s[l];
                            best_start_r[l] <= nstart_s[l];
                        end
                        hits_r[l] <= HIT_ZERO;
                    end
                    mism_r <= '0;
                    if (tap_idx_r != TAP_MAX) begin
                        tap_idx_r <= tap_idx_r + TAP_ONE;
                    end
                end
                ST_APPLY: begin
                    for (int l = 0; l < NUM_LANES; l++) begin
                        if (best_len_r[l] >= MIN_WIN) begin
                            tap_out_r[l*TAP_W +: TAP_W] <= center_s[l][TAP_W-1:0];
                            cal_fail_r[l]               <= 1'b0;
                        end else begin
                            tap_out_r[l*TAP_W +: TAP_W] <= DEF_TAP;
                            cal_fail_r[l]               <= 1'b1;
                        end
                        win_len_r[l*LEN_W +: LEN_W] <= best_len_r[l];
                    end
                    tap_ld_r   <= {NUM_LANES{1'b1}};
                    cal_busy_r <= 1'b0;
                end
                ST_DONE: begin
                    cal_done_r <= 1'b1;
                end
                default: begin
                    tap_ld_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csi_rx_dly_cal.sv
// Randomised bench for csi_rx_dly_cal: a lane model emits sync bytes per the loaded
// tap, and a run-list reference model predicts the chosen tap, window and fail flags.
module tb_csi_rx_dly_cal;

    localparam int NL    = 2;
    localparam int TW    = 5;
    localparam int SET   = 4;
    localparam int DW    = 48;
    localparam int MW    = 4;
    localparam int DT    = 3;
    localparam int NT    = 1 << TW;
    localparam int PER   = SET + DW + 2;
    localparam int SWEEP = NT * PER + 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 cal_start = 1'b0;
    logic [NL*8-1:0]      deser = '0;
    logic [NL*TW-1:0]     tap_out;
    logic [NL-1:0]        tap_ld;
    logic                 cal_busy;
    logic                 cal_done;
    logic [NL-1:0]        cal_fail;
    logic [NL*(TW+1)-1:0] win_len;

    csi_rx_dly_cal #(
        .NUM_LANES(NL), .TAP_W(TW), .SYNC_BYTE(8'hB8), .SETTLE(SET), .DWELL(DW),
        .MIN_HITS(2), .MIN_WINDOW(MW), .DEFAULT_TAP(DT)
    ) dut (
        .byte_clock(clk), .reset_n(rst_n), .cal_start(cal_start), .deser_in(deser),
        .tap_out(tap_out), .tap_ld(tap_ld), .cal_busy(cal_busy), .cal_done(cal_done),
        .cal_fail(cal_fail), .win_len(win_len)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    // mode per lane/tap: 0 quiet, 1 steady hits, 2 hits at alternating offsets, 3 one hit only
    int mode [NL][NT];
    int offa [NL];
    int offb [NL];
    int tap_cur [NL];
    int since = 0;
    int ld_cnt = 0;
    int exp_tap [NL];
    int exp_len [NL];
    int exp_fail [NL];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: list every maximal passing run, keep the longest (earliest on a tie).
    function automatic void model();
        for (int l = 0; l < NL; l++) begin
            int bl = 0;
            int bs = 0;
            for (int s = 0; s < NT; s++) begin
                if (mode[l][s] == 1 && (s == 0 || mode[l][s-1] != 1)) begin
                    int e = s;
                    while (e + 1 < NT && mode[l][e+1] == 1) e++;
                    if (e - s + 1 > bl) begin
                        bl = e - s + 1;
                        bs = s;
                    end
                end
            end
            exp_len[l]  = bl;
            exp_fail[l] = (bl < MW) ? 1 : 0;
            exp_tap[l]  = (bl < MW) ? DT : bs + bl / 2;
        end
    endfunction

    function automatic logic [7:0] lane_byte(input int l);
        logic [7:0]  sb;
        logic [15:0] v;
        int          m;
        int          k;
        sb = 8'hB8;
        if (tap_cur[l] < 0) return 8'h00;
        m = mode[l][tap_cur[l]];
        for (int i = 0; i < 4; i++) begin
            int e;
            e = 8 + 10 * i;
            if (m == 1 || m == 2 || (m == 3 && i == 0)) begin
                k = (m == 2 && (i % 2) == 1) ? offb[l] : offa[l];
                v = {8'h00, sb} << k;
                if (since == e - 1) return v[7:0];
                if (since == e) return v[15:8];
            end
        end
        return 8'h00;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (tap_ld !== '0) begin
            chk_eq("ld_all_lanes", tap_ld, {NL{1'b1}});
            for (int l = 0; l < NL; l++) begin
                tap_cur[l] = tap_out[l*TW +: TW];
                chk_eq($sformatf("ld_tap%0d_n%0d", l, ld_cnt), tap_out[l*TW +: TW],
                       (ld_cnt < NT) ? ld_cnt : exp_tap[l]);
            end
            ld_cnt++;
            since = 0;
        end else begin
            since++;
        end
        for (int l = 0; l < NL; l++) deser[l*8 +: 8] = lane_byte(l);
    endtask

    task automatic clear_modes();
        for (int l = 0; l < NL; l++) begin
            for (int t = 0; t < NT; t++) mode[l][t] = 0;
            offa[l] = 3;
            offb[l] = 6;
        end
    endtask

    task automatic set_run(input int l, input int lo, input int hi, input int m);
        for (int t = lo; t <= hi; t++) mode[l][t] = m;
    endtask

    task automatic rand_modes();
        for (int l = 0; l < NL; l++) begin
            bit p;
            offa[l] = $urandom_range(0, 7);
            offb[l] = (offa[l] + $urandom_range(1, 7)) % 8;
            p = $urandom_range(0, 1);
            for (int t = 0; t < NT; t++) begin
                if ($urandom_range(0, 99) < 20) p = !p;
                mode[l][t] = p ? 1 : 0;
                if (p && $urandom_range(0, 99) < 6) mode[l][t] = 2;
                if (!p && $urandom_range(0, 99) < 10) mode[l][t] = 3;
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        for (int l = 0; l < NL; l++) chk_eq({tag, "_tap"}, tap_out[l*TW +: TW], DT);
        chk_eq({tag, "_ld"}, tap_ld, 0);
        chk_eq({tag, "_busy"}, cal_busy, 0);
        chk_eq({tag, "_done"}, cal_done, 0);
        chk_eq({tag, "_fail"}, cal_fail, 0);
        chk_eq({tag, "_winlen"}, win_len, 0);
    endtask

    // One calibration; abort_n >= 0 pulls reset at that cycle, ign_n >= 0 pulses a stray cal_start.
    task automatic run_cal(input int abort_n, input int ign_n);
        int n;
        model();
        ld_cnt = 0;
        cal_start = 1'b1;
        step();
        cal_start = 1'b0;
        chk_eq("busy_after_start", cal_busy, 1);
        chk_eq("done_cleared", cal_done, 0);
        n = 0;
        while (cal_done !== 1'b1 && n < SWEEP + 100) begin
            cal_start = (n == ign_n);
            step();
            n++;
            if (n == abort_n) begin
                rst_n = 1'b0;
                #1;
                check_reset_state("abort");
                for (int l = 0; l < NL; l++) tap_cur[l] = -1;
                repeat (3) step();
                check_reset_state("abort_hold");
                rst_n = 1'b1;
                cal_start = 1'b0;
                return;
            end
        end
        cal_start = 1'b0;
        chk_eq("sweep_cycles", n, SWEEP);
        chk_eq("busy_at_done", cal_busy, 0);
        chk_eq("ld_count", ld_cnt, NT + 1);
        for (int l = 0; l < NL; l++) begin
            chk_eq($sformatf("final_tap%0d", l), tap_out[l*TW +: TW], exp_tap[l]);
            chk_eq($sformatf("win_len%0d", l), win_len[l*(TW+1) +: TW+1], exp_len[l]);
            chk_eq($sformatf("cal_fail%0d", l), cal_fail[l], exp_fail[l]);
        end
        repeat (3) step();
        chk_eq("done_held", cal_done, 1);
        chk_eq("ld_quiet_after", tap_ld, 0);
    endtask

    initial begin
        for (int l = 0; l < NL; l++) tap_cur[l] = -1;
        clear_modes();
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst_n = 1'b1;
        repeat (2) step();

        // Both lanes pass 8..20 at offset 3; first attempt is aborted in tap 9 dwell.
        set_run(0, 8, 20, 1);
        set_run(1, 8, 20, 1);
        run_cal(9 * PER + 30, -1);
        repeat (2) step();
        run_cal(-1, -1);

        // Two windows on lane 0, top-edge run on lane 1; stray cal_start at tap 5.
        clear_modes();
        set_run(0, 2, 5, 1);
        set_run(0, 10, 20, 1);
        set_run(1, 25, 31, 1);
        run_cal(-1, 5 * PER + 20);

        // Lane 0 window too short; lane 1 unaffected.
        clear_modes();
        set_run(0, 7, 9, 1);
        set_run(1, 8, 20, 1);
        run_cal(-1, -1);

        // Tap 12 sees sync at alternating offsets 2 and 5 and must fail.
        clear_modes();
        offa[0] = 2;
        offb[0] = 5;
        set_run(0, 8, 20, 1);
        mode[0][12] = 2;
        set_run(1, 8, 20, 1);
        mode[1][12] = 3;
        run_cal(-1, -1);

        for (int r = 0; r < 6; r++) begin
            rand_modes();
            run_cal(-1, (r % 2 == 0) ? $urandom_range(10, SWEEP - 10) : -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
